cmos_uploader: RTL

Read-side counterpart of the ROM/NVRAM download path. It serves HPS upload requests by fetching bytes from the game's 1024×4-bit battery-backed CMOS RAM, so high scores and audits can be saved to SD. It sits between `hps_io` (`ioctl_upload` / `ioctl_rd` / `ioctl_din`) and a read port on the core's CMOS RAM. Optionally it tracks core writes and requests an autosave at vertical blank.

---
 rtl/cmos_uploader.sv | 130 +++++++++++++
 1 files changed

// File: rtl/cmos_uploader.sv
// cmos_uploader: serves HPS upload reads from the 1024x4 battery-backed CMOS RAM.
// Latency: RD_LAT+2 clocks from ioctl_rd to ioctl_din; out-of-range addresses answer 8'hFF next clock.
// Backpressure: ioctl_wait is high while a CMOS fetch is outstanding; ioctl_rd arriving outside IDLE is ignored.
//
// Ports: clk_sys/reset_n (async active-low); ioctl_upload/index/rd/addr in, ioctl_din/ioctl_wait out
// (hps_io side); cmos_addr/cmos_rd out, cmos_q in (CMOS read port); cmos_we/vblank/autosave_en in,
// upload_req out (autosave, only built with CMOS_UPLOADER_AUTOSAVE_EN defined; otherwise upload_req=0).
module cmos_uploader #(
   parameter int          DEPTH  = 1024,
   parameter int          RD_LAT = 1,
   parameter logic [7:0]  INDEX  = 8'd4
) (
   input  logic        clk_sys,
   input  logic        reset_n,
   input  logic        ioctl_upload,
   input  logic [7:0]  ioctl_index,
   input  logic        ioctl_rd,
   input  logic [24:0] ioctl_addr,
   output logic [7:0]  ioctl_din,
   output logic        ioctl_wait,
   output logic [9:0]  cmos_addr,
   output logic        cmos_rd,
   input  logic [3:0]  cmos_q,
   input  logic        cmos_we,
   input  logic        vblank,
   input  logic        autosave_en,
   output logic        upload_req
);

   typedef enum logic [1:0] {IDLE, FETCH, WAIT, DONE} state_t;

   state_t     state;
   logic [1:0] lat_cnt;

   logic sel;
   logic in_range;
   logic lat_last;

   assign sel      = (ioctl_index == INDEX);
   assign in_range = (ioctl_addr < 25'(DEPTH));
   assign lat_last = (lat_cnt == 2'(RD_LAT - 1));

   // Dropping ioctl_upload aborts from any state; a foreign index freezes the block entirely.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         lat_cnt    <= 2'd0;
         ioctl_din  <= 8'h00;
         ioctl_wait <= 1'b0;
         cmos_addr  <= 10'd0;
         cmos_rd    <= 1'b0;
      end else if (!ioctl_upload) begin
         state      <= IDLE;
         ioctl_wait <= 1'b0;
         cmos_rd    <= 1'b0;
      end else if (sel) begin
         case (state)
            IDLE: begin
               if (ioctl_rd) begin
                  if (in_range) begin
                     state      <= FETCH;
                     cmos_rd    <= 1'b1;
                     cmos_addr  <= ioctl_addr[9:0];
                     ioctl_wait <= 1'b1;
                  end else begin
                     // Beyond the RAM the bus floats high.
                     ioctl_din <= 8'hFF;
                  end
               end
            end
            FETCH: begin
               cmos_rd <= 1'b0;
               lat_cnt <= 2'd0;
               state   <= WAIT;
            end
            WAIT: begin
               if (lat_last) begin
                  ioctl_din  <= {4'hF, cmos_q};
                  ioctl_wait <= 1'b0;
                  state      <= DONE;
               end else begin
                  lat_cnt <= lat_cnt + 2'd1;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

`ifdef CMOS_UPLOADER_AUTOSAVE_EN
   logic dirty;
   logic vblank_d;
   logic upload_d;
   logic served_last;
   logic last_hit;
   logic upload_fall;

   // A fetch of the final nibble completes this cycle.
   assign last_hit    = ioctl_upload && sel && (state == WAIT) && lat_last &&
                        (cmos_addr == 10'(DEPTH - 1));
   assign upload_fall = upload_d && !ioctl_upload;

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         dirty       <= 1'b0;
         vblank_d    <= 1'b0;
         upload_d    <= 1'b0;
         served_last <= 1'b0;
         upload_req  <= 1'b0;
      end else begin
         vblank_d    <= vblank;
         upload_d    <= ioctl_upload;
         // Remembered only for the current session; cleared once the session ends.
         served_last <= ioctl_upload && (served_last || last_hit);
         // A write in the same cycle as the clear keeps the RAM marked dirty.
         if (cmos_we)
            dirty <= 1'b1;
         else if (upload_fall && served_last)
            dirty <= 1'b0;
         upload_req <= vblank && !vblank_d && dirty && autosave_en && !ioctl_upload;
      end
   end
`else
   logic unused_autosave;
   assign unused_autosave = &{1'b0, cmos_we, vblank, autosave_en};
   assign upload_req      = 1'b0;
`endif

endmodule
